// File: rtl/fabric_config_loader.sv
// Fabric configuration loader: serialises host words into the config chain.
// Accepts ceil(CHAIN_LEN/WORD_W) words per session, shifts LSB first, then commits.
//
// Ports:
//   clk        fabric clock
//   rst        synchronous active-high reset
//   start      one-cycle session request, honoured only while idle
//   in_data    host configuration word
//   in_valid   in_data valid
//   in_ready   loader takes a word this cycle
//   cfg_cen    chain shift enable, high only while cfg_shift carries a bit
//   cfg_shift  serial bit into the first tile's shift_in
//   cfg_set    one-cycle commit to every tile's set_in
//   busy       session in progress
//   done       one-cycle session completion pulse
module fabric_config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_cen,
    output logic              cfg_shift,
    output logic              cfg_set,
    output logic              busy,
    output logic              done
);

    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_SET,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, bit_inc;
    logic [WB_W-1:0]   wbit_q, wbit_d, wbit_inc;

    assign bit_inc  = bit_cnt_q + CNT_W'(1);
    assign wbit_inc = wbit_q + WB_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            wbit_q    <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            wbit_q    <= wbit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        wbit_d    = wbit_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    bit_cnt_d = '0;
                    wbit_d    = '0;
                end
            end
            S_LOAD: begin
                // in_ready is high throughout LOAD, so valid alone completes the handshake
                if (in_valid) begin
                    sreg_d  = in_data;
                    wbit_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sreg_d    = sreg_q >> 1;
                bit_cnt_d = bit_inc;
                wbit_d    = wbit_inc;
                // Chain end wins over word end; leftover word bits are dropped
                if (bit_inc == CNT_W'(CHAIN_LEN)) begin
                    state_d = S_SET;
                end else if (wbit_inc == WB_W'(WORD_W)) begin
                    state_d = S_LOAD;
                end
            end
            S_SET: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_LOAD);
    assign cfg_cen   = (state_q == S_SHIFT);
    assign cfg_shift = (state_q == S_SHIFT) & sreg_q[0];
    assign cfg_set   = (state_q == S_SET);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_fabric_config_loader.sv
// Testbench for fabric_config_loader: two instances (chain of 8 and of 6 bits).
// A queue-based session model is compared against both DUTs every cycle.
module tb_fabric_config_loader;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rst;
    logic [1:0]   start;
    logic [1:0]   in_valid;
    logic [W-1:0] in_data [2];
    logic [1:0]   in_ready;
    logic [1:0]   cfg_cen;
    logic [1:0]   cfg_shift;
    logic [1:0]   cfg_set;
    logic [1:0]   busy;
    logic [1:0]   done;

    fabric_config_loader #(.WORD_W(W), .CHAIN_LEN(8)) u0 (
        .clk(clk), .rst(rst[0]), .start(start[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .cfg_cen(cfg_cen[0]), .cfg_shift(cfg_shift[0]), .cfg_set(cfg_set[0]),
        .busy(busy[0]), .done(done[0])
    );

    fabric_config_loader #(.WORD_W(W), .CHAIN_LEN(6)) u1 (
        .clk(clk), .rst(rst[1]), .start(start[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .cfg_cen(cfg_cen[1]), .cfg_shift(cfg_shift[1]), .cfg_set(cfg_set[1]),
        .busy(busy[1]), .done(done[1])
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    int CL [2] = '{8, 6};

    // Model: bits still owed to the chain from the current word, bits sent,
    // and a tail countdown (2 = commit next, 1 = done next).
    bit m_busy [2];
    int m_sent [2];
    int m_tail [2];
    bit m_q [2][$];

    // Observed from the DUT for literal checks
    bit cap [2][$];
    int n_set [2];
    int n_done [2];
    bit prev_cen [2];

    task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)",
                     name, id, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int n;
        for (int id = 0; id < 2; id++) begin
            if (rst[id]) begin
                m_busy[id] = 1'b0;
                m_sent[id] = 0;
                m_tail[id] = 0;
                m_q[id].delete();
            end else if (!m_busy[id]) begin
                if (start[id]) begin
                    m_busy[id] = 1'b1;
                    m_sent[id] = 0;
                end
            end else if (m_tail[id] == 2) begin
                m_tail[id] = 1;
            end else if (m_tail[id] == 1) begin
                m_tail[id] = 0;
                m_busy[id] = 1'b0;
            end else if (m_q[id].size() > 0) begin
                void'(m_q[id].pop_front());
                m_sent[id]++;
                if (m_sent[id] == CL[id]) begin
                    m_q[id].delete();
                    m_tail[id] = 2;
                end
            end else if (in_valid[id]) begin
                n = CL[id] - m_sent[id];
                if (n > W) n = W;
                for (int k = 0; k < n; k++) m_q[id].push_back(in_data[id][k]);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int id = 0; id < 2; id++) begin
                bit e_cen;
                bit e_shift;
                e_cen   = (m_q[id].size() > 0);
                e_shift = e_cen ? m_q[id][0] : 1'b0;
                chk("in_ready", id, 32'(in_ready[id]),
                    32'(m_busy[id] && m_tail[id] == 0 && !e_cen));
                chk("cfg_cen", id, 32'(cfg_cen[id]), 32'(e_cen));
                chk("cfg_shift", id, 32'(cfg_shift[id]), 32'(e_shift));
                chk("cfg_set", id, 32'(cfg_set[id]), 32'(m_tail[id] == 2));
                chk("done", id, 32'(done[id]), 32'(m_tail[id] == 1));
                chk("busy", id, 32'(busy[id]), 32'(m_busy[id]));
                if (cfg_cen[id] === 1'b1) cap[id].push_back(cfg_shift[id]);
                if (cfg_set[id] === 1'b1) begin
                    n_set[id]++;
                    chk("set_after_cen", id, 32'(prev_cen[id]), 32'd1);
                end
                if (done[id] === 1'b1) n_done[id]++;
                prev_cen[id] = cfg_cen[id];
            end
        end
    end

    task automatic do_start(int id);
        @(posedge clk);
        #1 start[id] = 1'b1;
        @(posedge clk);
        #1 start[id] = 1'b0;
    endtask

    task automatic send_word(int id, logic [W-1:0] w);
        in_data[id]  = w;
        in_valid[id] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready[id] === 1'b1) begin
                @(posedge clk);
                #1 in_valid[id] = 1'b0;
                return;
            end
        end
        checks++;
        fails++;
        $display("FAIL handshake_timeout dut%0d: in_ready never rose", id);
        in_valid[id] = 1'b0;
    endtask

    task automatic wait_done(int id, int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done[id] === 1'b1) begin
                lat = cyc - t0;
                return;
            end
        end
        checks++;
        fails++;
        $display("FAIL done_timeout dut%0d: done never pulsed", id);
    endtask

    task automatic new_session(int id);
        cap[id].delete();
        n_set[id]  = 0;
        n_done[id] = 0;
    endtask

    task automatic check_bits(string name, int id, logic [7:0] exp, int n);
        chk({name, "_count"}, id, 32'(cap[id].size()), 32'(n));
        for (int k = 0; k < n && k < cap[id].size(); k++)
            chk($sformatf("%s_bit%0d", name, k), id, 32'(cap[id][k]), 32'(exp[k]));
    endtask

    task automatic run2(int id, logic [W-1:0] w0, logic [W-1:0] w1,
                        int stall, output int lat);
        int t0;
        new_session(id);
        do_start(id);
        t0 = cyc;
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
        end
        send_word(id, w0);
        send_word(id, w1);
        wait_done(id, t0, lat);
    endtask

    initial begin
        int lat;
        int lat1;
        int t0;
        bit hit;
        rst      = 2'b11;
        start    = 2'b00;
        in_valid = 2'b00;
        in_data[0] = '0;
        in_data[1] = '0;

        @(posedge clk);
        #1 cmp_en = 1'b1;
        @(negedge clk);
        for (int id = 0; id < 2; id++) begin
            chk("rst_busy", id, 32'(busy[id]), 32'd0);
            chk("rst_ready", id, 32'(in_ready[id]), 32'd0);
            chk("rst_cen", id, 32'(cfg_cen[id]), 32'd0);
            chk("rst_set", id, 32'(cfg_set[id]), 32'd0);
            chk("rst_done", id, 32'(done[id]), 32'd0);
        end
        @(posedge clk);
        #1 rst = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // 1: back-to-back words 0xA, 0x5
        run2(0, 4'hA, 4'h5, 0, lat1);
        check_bits("s1", 0, 8'h5A, 8);
        chk("s1_latency", 0, 32'(lat1), 32'd11);
        chk("s1_sets", 0, 32'(n_set[0]), 32'd1);
        @(negedge clk);
        chk("s1_idle", 0, 32'(busy[0]), 32'd0);

        // 2: three stall cycles before the first word
        run2(0, 4'hA, 4'h5, 3, lat);
        check_bits("s2", 0, 8'h5A, 8);
        chk("s2_latency", 0, 32'(lat), 32'd14);

        // 3: chain of 6, third word held valid must not be consumed
        new_session(1);
        do_start(1);
        t0 = cyc;
        send_word(1, 4'h3);
        send_word(1, 4'hF);
        in_data[1]  = 4'hE;
        in_valid[1] = 1'b1;
        wait_done(1, t0, lat);
        check_bits("s3", 1, 8'h33, 6);
        chk("s3_latency", 1, 32'(lat), 32'd9);
        chk("s3_sets", 1, 32'(n_set[1]), 32'd1);
        repeat (3) @(negedge clk);
        chk("s3_ready_idle", 1, 32'(in_ready[1]), 32'd0);
        in_valid[1] = 1'b0;

        // 4: reset after three shifted bits aborts the session
        new_session(0);
        do_start(0);
        send_word(0, 4'hA);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            #1 hit = (cap[0].size() >= 3);
        end
        chk("s4_reached3", 0, 32'(cap[0].size()), 32'd3);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("s4_cen_after_rst", 0, 32'(cfg_cen[0]), 32'd0);
        chk("s4_set_after_rst", 0, 32'(cfg_set[0]), 32'd0);
        #1 rst[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("s4_no_set", 0, 32'(n_set[0]), 32'd0);
        chk("s4_no_done", 0, 32'(n_done[0]), 32'd0);
        run2(0, 4'hA, 4'h5, 0, lat);
        check_bits("s4b", 0, 8'h5A, 8);
        chk("s4b_latency", 0, 32'(lat), 32'd11);

        // 5: extra start pulse mid-SHIFT is ignored
        fork
            run2(0, 4'hA, 4'h5, 0, lat);
            begin
                hit = 1'b0;
                for (int i = 0; i < 40 && !hit; i++) begin
                    @(negedge clk);
                    hit = (cfg_cen[0] === 1'b1);
                end
                @(posedge clk);
                #1 start[0] = 1'b1;
                @(posedge clk);
                #1 start[0] = 1'b0;
            end
        join
        check_bits("s5", 0, 8'h5A, 8);
        chk("s5_latency", 0, 32'(lat), 32'(lat1));
        chk("s5_sets", 0, 32'(n_set[0]), 32'd1);

        // 6: word offered while idle waits for the session
        in_data[0]  = 4'h7;
        in_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("s6_idle_ready", 0, 32'(in_ready[0]), 32'd0);
            chk("s6_idle_cen", 0, 32'(cfg_cen[0]), 32'd0);
        end
        run2(0, 4'h7, 4'h0, 0, lat);
        check_bits("s6", 0, 8'h07, 8);
        chk("s6_latency", 0, 32'(lat), 32'd11);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Drives the fabric configuration shift chain from a word-wide host stream.
- Sits at the head of the chain. Its serial output feeds the first tile's shift_in; its cen and set outputs fan out to every tile's cen and set_in.
- Each session serialises exactly CHAIN_LEN bits, LSB of word 0 first, then issues a one-cycle commit (set) and a done pulse.

Parameters:
- WORD_W, 32, width of host configuration words.
- CHAIN_LEN, 1024, total configuration bits in the chain (must be >= 1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the session bit counter.

Ports:
- clk  input  1  fabric clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request to begin a session; ignored unless IDLE.
- in_data  input  WORD_W  configuration word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- cfg_cen  output  1  chain shift enable; high exactly when cfg_shift carries a valid bit.
- cfg_shift  output  1  serial bit to the chain's shift_in.
- cfg_set  output  1  one-cycle commit to every tile's set_in.
- busy  output  1  session in progress (state != IDLE).
- done  output  1  one-cycle pulse when a session completes.

Behaviour:
- Reset: state IDLE; shift register, bit counter and word-bit counter cleared. All outputs are 0.
- Reset mid-session aborts the session. cfg_cen and cfg_set are 0 on the cycle after rst is sampled high. No commit occurs, and the partially shifted chain contents are left as-is.
- All outputs are decoded from registered state and registered data only. None are combinational from inputs.
- States:
  - IDLE: start=1 -> LOAD; clear both counters.
  - LOAD: in_ready=1. in_valid & in_ready -> latch in_data into the shift register, clear the word-bit counter, go to SHIFT. No in_valid -> remain in LOAD with cfg_cen=0; the chain holds.
  - SHIFT: cfg_cen=1 and cfg_shift=sreg[0]. Each cycle: sreg shifts right by 1, the bit counter increments and the word-bit counter increments.
    - Bit counter reaches CHAIN_LEN on this cycle -> SET, with priority over end-of-word.
    - Else word-bit counter reaches WORD_W on this cycle -> LOAD.
  - SET: cfg_set=1 and cfg_cen=0 for exactly one cycle -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency:
  - The first bit appears on cfg_shift, with cfg_cen=1, the cycle after the word handshake.
  - One handshake-cycle bubble (cfg_cen=0) occurs between consecutive words.
  - cfg_set follows the CHAIN_LEN-th cen cycle by one cycle; done follows cfg_set by one cycle.
- Word consumption:
  - Exactly ceil(CHAIN_LEN/WORD_W) words are accepted per session.
  - If CHAIN_LEN is not a multiple of WORD_W, the upper bits of the final word are discarded.
  - No further word is accepted after the final one; in_ready stays 0 until the next session's LOAD.
- start while busy is ignored, with no restart and no counter disturbance.
- in_valid outside LOAD is not consumed.
- cfg_shift is 0 whenever cfg_cen=0.
- busy is 1 in LOAD, SHIFT, SET and DONE.

Test Plan (WORD_W=4, CHAIN_LEN=8 unless noted):
1. start, then words 0xA and 0x5 presented back-to-back -> cfg_shift on cen cycles is 0,1,0,1,1,0,1,0; cfg_cen is low one cycle between the words. cfg_set is high for 1 cycle after the 8th cen cycle, done the cycle after, and busy returns to 0.
2. Same words with in_valid held low 3 cycles before word 1 -> cfg_cen low for those 3 extra cycles. Bit sequence and total cen count (8) are unchanged.
3. CHAIN_LEN=6, words 0x3 then 0xF -> bits 1,1,0,0,1,1 and cfg_set after 6 cen cycles. in_ready stays 0 while a third word sits valid; it is not consumed.
4. rst asserted after 3 cen cycles of word 0 -> cfg_cen=0 on the next cycle; cfg_set and done never assert. A fresh start then completes a full 8-bit session normally.
5. start pulsed again mid-SHIFT -> ignored; sequence and completion timing identical to scenario 1.
6. in_valid=1 with 0x7 while IDLE for 5 cycles -> in_ready=0 and cfg_cen=0 throughout; after start, 0x7 is accepted as word 0.
